// File: rtl/sprite_scheduler.sv
// sprite_scheduler: walks a double-buffered sprite table once per frame and
// launches one blit per enabled entry, waiting for each completion in turn.
`timescale 1ns/1ps
`default_nettype none

module sprite_scheduler #(
  parameter int NUM_SPRITES = 8,
  parameter int IDX_W       = $clog2(NUM_SPRITES)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_start,
  input  logic              tbl_we,
  input  logic [IDX_W-1:0]  tbl_index,
  input  logic              tbl_enable,
  input  logic [9:0]        tbl_x,
  input  logic [9:0]        tbl_y,
  input  logic [24:0]       tbl_addr,
  input  logic              wrote_sprite,
  input  logic              overrun_clr,
  output logic              new_sprite,
  output logic [9:0]        sprite_x_pos,
  output logic [9:0]        sprite_y_pos,
  output logic [24:0]       sprite_address,
  output logic              busy,
  output logic              frame_done,
  output logic              overrun,
  output logic [IDX_W:0]    blit_count
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SCAN      = 3'd1,
    LAUNCH    = 3'd2,
    WAIT_DONE = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx;

  logic             stg_en   [NUM_SPRITES];
  logic [9:0]       stg_x    [NUM_SPRITES];
  logic [9:0]       stg_y    [NUM_SPRITES];
  logic [24:0]      stg_addr [NUM_SPRITES];
  logic             act_en   [NUM_SPRITES];
  logic [9:0]       act_x    [NUM_SPRITES];
  logic [9:0]       act_y    [NUM_SPRITES];
  logic [24:0]      act_addr [NUM_SPRITES];

  logic last;
  logic accept;

  assign last   = (idx == IDX_W'(NUM_SPRITES - 1));
  assign accept = frame_start && (state == IDLE);

  // Non-blocking copy sees the staging contents from before a same-cycle write.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        stg_en[i]   <= 1'b0;
        stg_x[i]    <= '0;
        stg_y[i]    <= '0;
        stg_addr[i] <= '0;
        act_en[i]   <= 1'b0;
        act_x[i]    <= '0;
        act_y[i]    <= '0;
        act_addr[i] <= '0;
      end
    end else begin
      if (tbl_we) begin
        stg_en[tbl_index]   <= tbl_enable;
        stg_x[tbl_index]    <= tbl_x;
        stg_y[tbl_index]    <= tbl_y;
        stg_addr[tbl_index] <= tbl_addr;
      end
      if (accept) begin
        for (int i = 0; i < NUM_SPRITES; i++) begin
          act_en[i]   <= stg_en[i];
          act_x[i]    <= stg_x[i];
          act_y[i]    <= stg_y[i];
          act_addr[i] <= stg_addr[i];
        end
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    new_sprite = 1'b0;
    frame_done = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE:      if (frame_start) state_nxt = SCAN;
      SCAN: begin
        if (act_en[idx]) state_nxt = LAUNCH;
        else if (last)   state_nxt = DONE;
      end
      LAUNCH: begin
        new_sprite = 1'b1;
        state_nxt  = WAIT_DONE;
      end
      WAIT_DONE: if (wrote_sprite) state_nxt = last ? DONE : SCAN;
      DONE: begin
        frame_done = 1'b1;
        state_nxt  = IDLE;
      end
      default:   state_nxt = IDLE;
    endcase
  end

  // Sprite outputs load on the SCAN->LAUNCH transition and hold for the whole blit.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      idx            <= '0;
      blit_count     <= '0;
      overrun        <= 1'b0;
      sprite_x_pos   <= '0;
      sprite_y_pos   <= '0;
      sprite_address <= '0;
    end else begin
      if (accept) begin
        idx        <= '0;
        blit_count <= '0;
      end else if (state == SCAN && !act_en[idx] && !last) begin
        idx <= idx + 1'b1;
      end else if (state == WAIT_DONE && wrote_sprite) begin
        blit_count <= blit_count + 1'b1;
        if (!last) idx <= idx + 1'b1;
      end

      if (state == SCAN && act_en[idx]) begin
        sprite_x_pos   <= act_x[idx];
        sprite_y_pos   <= act_y[idx];
        sprite_address <= act_addr[idx];
      end

      if (frame_start && state != IDLE) overrun <= 1'b1;
      else if (overrun_clr)             overrun <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sprite_scheduler.sv
// tb_sprite_scheduler: scoreboard bench with a table-level reference model,
// a stalling blitter model and a decoupled output monitor.
`timescale 1ns/1ps
`default_nettype none

module tb_sprite_scheduler;
  localparam int N  = 8;
  localparam int IW = 3;

  logic          Clk = 1'b0, Reset = 1'b1, frame_start = 1'b0, tbl_we = 1'b0;
  logic          tbl_enable = 1'b0, overrun_clr = 1'b0;
  logic [IW-1:0] tbl_index = '0;
  logic [9:0]    tbl_x = '0, tbl_y = '0;
  logic [24:0]   tbl_addr = '0;
  logic          blit_ws = 1'b0, spur_ws = 1'b0;
  logic          wrote_sprite;
  logic          new_sprite, busy, frame_done, overrun;
  logic [9:0]    sprite_x_pos, sprite_y_pos;
  logic [24:0]   sprite_address;
  logic [IW:0]   blit_count;

  assign wrote_sprite = blit_ws | spur_ws;

  sprite_scheduler #(.NUM_SPRITES(N), .IDX_W(IW)) dut (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .tbl_we(tbl_we),
    .tbl_index(tbl_index), .tbl_enable(tbl_enable), .tbl_x(tbl_x), .tbl_y(tbl_y),
    .tbl_addr(tbl_addr), .wrote_sprite(wrote_sprite), .overrun_clr(overrun_clr),
    .new_sprite(new_sprite), .sprite_x_pos(sprite_x_pos), .sprite_y_pos(sprite_y_pos),
    .sprite_address(sprite_address), .busy(busy), .frame_done(frame_done),
    .overrun(overrun), .blit_count(blit_count)
  );

  always #5 Clk = ~Clk;

  typedef struct { logic en; logic [9:0] x; logic [9:0] y; logic [24:0] a; } ent_t;
  typedef struct { int cnt; int done_cyc; } frm_t;

  ent_t stg_m [N];
  ent_t act_m [N];
  ent_t blit_q [$];
  frm_t frame_q [$];
  int   cyc = 0, checks = 0, passes = 0;
  int   frames_started = 0, frames_done = 0, last_cnt = 0;
  bit   stall = 1'b0, blit_abort = 1'b0, exp_ovr = 1'b0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic ent_t mk(input bit en, input int x, input int y, input int a);
    ent_t e;
    e.en = en; e.x = 10'(x); e.y = 10'(y); e.a = 25'(a);
    return e;
  endfunction

  function automatic ent_t rand_ent();
    return mk(1'($urandom), int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
              int'($urandom_range(0, 32'h1FF_FFFF)));
  endfunction

  // Monitor: every launch must match the next expected blit, every frame end the next summary.
  initial begin
    ent_t e;
    frm_t f;
    forever begin
      @(negedge Clk);
      if (!Reset) begin
        if (new_sprite) begin
          if (blit_q.size() == 0) check("unexpected_launch", 64'd1, 64'd0);
          else begin
            e = blit_q.pop_front();
            check("blit_params", {sprite_x_pos, sprite_y_pos, sprite_address}, {e.x, e.y, e.a});
          end
        end
        if (frame_done) begin
          if (frame_q.size() == 0) check("unexpected_frame_done", 64'd1, 64'd0);
          else begin
            f = frame_q.pop_front();
            check("blit_count_at_done", 64'(blit_count), 64'(f.cnt));
            if (f.done_cyc >= 0) check("frame_done_latency", 64'(cyc), 64'(f.done_cyc));
          end
          frames_done++;
        end
      end
    end
  end

  // Blitter model: random blit length, optional stall, parameters must hold throughout.
  initial begin
    int delay, n;
    logic [44:0] cap;
    forever begin
      @(negedge Clk);
      if (new_sprite && !Reset) begin
        cap   = {sprite_x_pos, sprite_y_pos, sprite_address};
        delay = int'($urandom_range(1, 5));
        n     = 0;
        while (!blit_abort && (n < delay || stall)) begin
          @(negedge Clk);
          if (!blit_abort)
            check("hold_stable", {new_sprite, sprite_x_pos, sprite_y_pos, sprite_address}, {1'b0, cap});
          if (!stall) n++;
        end
        if (!blit_abort) begin
          @(posedge Clk); #1 blit_ws = 1'b1;
          @(posedge Clk); #1 blit_ws = 1'b0;
        end
      end
    end
  end

  task automatic write_entry(input int i, input ent_t e);
    @(posedge Clk); #1;
    tbl_we = 1'b1; tbl_index = IW'(i);
    tbl_enable = e.en; tbl_x = e.x; tbl_y = e.y; tbl_addr = e.a;
    stg_m[i] = e;
    @(posedge Clk); #1 tbl_we = 1'b0;
  endtask

  // Reference: an accepted frame blits every enabled snapshot entry in index order.
  task automatic start_frame(input bit wr, input int wi, input ent_t e);
    int cnt;
    frm_t f;
    @(posedge Clk); #1;
    frame_start = 1'b1;
    if (wr) begin
      tbl_we = 1'b1; tbl_index = IW'(wi);
      tbl_enable = e.en; tbl_x = e.x; tbl_y = e.y; tbl_addr = e.a;
    end
    if (frames_started == frames_done) begin
      cnt   = 0;
      act_m = stg_m;
      for (int i = 0; i < N; i++)
        if (act_m[i].en) begin blit_q.push_back(act_m[i]); cnt++; end
      f.cnt      = cnt;
      f.done_cyc = (cnt == 0) ? cyc + N + 1 : -1;
      frame_q.push_back(f);
      last_cnt = cnt;
      frames_started++;
    end else begin
      exp_ovr = 1'b1;
    end
    if (wr) stg_m[wi] = e;
    @(posedge Clk); #1;
    frame_start = 1'b0; tbl_we = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (frames_started != frames_done && n < 3000) begin
      @(negedge Clk); n++;
    end
    check("frame_complete", 64'(frames_done), 64'(frames_started));
    @(negedge Clk);
    check("all_blits_issued", 64'(blit_q.size()), 64'd0);
    check("idle_after_frame", {63'd0, busy}, 64'd0);
  endtask

  task automatic pulse_spur();
    @(posedge Clk); #1 spur_ws = 1'b1;
    @(posedge Clk); #1 spur_ws = 1'b0;
  endtask

  initial begin
    ent_t z;
    z = mk(1'b0, 0, 0, 0);
    for (int i = 0; i < N; i++) begin stg_m[i] = z; act_m[i] = z; end

    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("reset_state", {new_sprite, busy, frame_done, overrun, blit_count,
                          sprite_x_pos, sprite_y_pos, sprite_address}, 64'd0);
    @(posedge Clk); #1 Reset = 1'b0;

    // Entries 0 and 3 enabled; first launch two cycles after the pulse.
    write_entry(0, mk(1'b1, 10, 20, 25'h123));
    write_entry(3, mk(1'b1, 100, 50, 25'h1000));
    start_frame(1'b0, 0, z);
    @(negedge Clk);
    check("busy_then_scan", {62'd0, busy, new_sprite}, 64'b10);
    @(negedge Clk);
    check("first_launch_latency", {63'd0, new_sprite}, 64'd1);
    wait_idle();
    check("two_blits", 64'(blit_count), 64'd2);

    pulse_spur();
    @(negedge Clk);
    check("spurious_in_idle", 64'(blit_count), 64'(last_cnt));

    // frame_start while stalled in WAIT_DONE.
    stall = 1'b1;
    start_frame(1'b0, 0, z);
    repeat (5) @(negedge Clk);
    start_frame(1'b0, 0, z);
    @(negedge Clk);
    check("overrun_set", {63'd0, overrun}, {63'd0, exp_ovr});
    stall = 1'b0;
    wait_idle();
    check("overrun_sticky", {63'd0, overrun}, {63'd0, exp_ovr});
    @(posedge Clk); #1 overrun_clr = 1'b1; exp_ovr = 1'b0;
    @(posedge Clk); #1 overrun_clr = 1'b0;
    @(negedge Clk);
    check("overrun_cleared", {63'd0, overrun}, {63'd0, exp_ovr});

    // Table write coincident with frame_start lands in the following frame.
    write_entry(1, mk(1'b1, 7, 8, 25'h777));
    start_frame(1'b1, 1, mk(1'b1, 300, 400, 25'h1ABCDE));
    wait_idle();
    start_frame(1'b0, 0, z);
    wait_idle();

    for (int f = 0; f < 6; f++) begin
      for (int w = 0; w < int'($urandom_range(1, 6)); w++)
        write_entry(int'($urandom_range(0, N - 1)), rand_ent());
      start_frame(1'($urandom), int'($urandom_range(0, N - 1)), rand_ent());
      wait_idle();
    end

    // Asynchronous reset in the middle of a stalled blit.
    write_entry(0, mk(1'b1, 55, 66, 25'h4242));
    stall = 1'b1;
    start_frame(1'b0, 0, z);
    repeat (5) @(negedge Clk);
    start_frame(1'b0, 0, z);
    blit_abort = 1'b1;
    repeat (2) @(negedge Clk);
    check("overrun_before_reset", {63'd0, overrun}, {63'd0, exp_ovr});
    #2 Reset = 1'b1;
    #1 check("async_reset", {new_sprite, busy, frame_done, overrun, blit_count,
                             sprite_x_pos, sprite_y_pos, sprite_address}, 64'd0);
    for (int i = 0; i < N; i++) begin stg_m[i] = z; act_m[i] = z; end
    blit_q.delete();
    frame_q.delete();
    frames_started = frames_done;
    exp_ovr = 1'b0;
    stall   = 1'b0;
    @(posedge Clk); #1 Reset = 1'b0; blit_abort = 1'b0;

    // Clean restart: all-disabled table, spurious completion during SCAN.
    start_frame(1'b0, 0, z);
    pulse_spur();
    wait_idle();
    check("no_blits_after_reset", 64'(blit_count), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
